sparc_exu_eclccr_mt: RTL

Parametrised per-thread condition-code register file for the EXU ECL, sized for NTHR threads of CCW-bit CCs (xcc:icc).
- Pipelines setcc from D to W and commits ALU, WRCCR and TLU-restore CCs at W.
- Accepts a late W2 write port from long-latency ops (divide).
- Forwards the youngest in-flight CCs to the D stage.
- New in this generation: a per-thread late-write pending scoreboard with a D-stage stall, W2 forwarding, and synchronous reset.

---
 rtl/sparc_exu_pkg.sv | 12 +
 rtl/sparc_exu_ccr_thr.sv | 38 +++
 rtl/sparc_exu_eclccr_mt.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sparc_exu_pkg.sv
// Shared EXU constants: default thread/CC geometry and CC field positions.
package sparc_exu_pkg;

  localparam int NTHR_DEF   = 4;
  localparam int TIDW_DEF   = 2;
  localparam int CCW_DEF    = 8;

  // CC layout is {xcc, icc}, each 4 bits {n, z, v, c}
  localparam int CC_ICC_LSB = 0;
  localparam int CC_XCC_LSB = 4;

endpackage

// File: rtl/sparc_exu_ccr_thr.sv
// One thread's condition-code register with a two-port priority write
// (W over W2) and its late-write pending bit.
module sparc_exu_ccr_thr
  import sparc_exu_pkg::*;
#(
  parameter int CCW = CCW_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_w,
  input  logic [CCW-1:0] data_w,
  input  logic           wr_w2,
  input  logic [CCW-1:0] data_w2,
  input  logic           set_pend,
  input  logic           clr_pend,
  output logic [CCW-1:0] ccr,
  output logic           pending
);

  // W is the younger writer, so it wins a same-thread collision with W2
  always_ff @(posedge clk) begin
    if (reset) begin
      ccr     <= '0;
      pending <= 1'b0;
    end else begin
      if (wr_w)
        ccr <= data_w;
      else if (wr_w2)
        ccr <= data_w2;

      if (set_pend)
        pending <= 1'b1;
      else if (clr_pend)
        pending <= 1'b0;
    end
  end

endmodule

// File: rtl/sparc_exu_eclccr_mt.sv
// Per-thread CC register file: setcc pipeline D..W, late W2 write port,
// D-stage forwarding and a late-write pending scoreboard with stall.
module sparc_exu_eclccr_mt
  import sparc_exu_pkg::*;
#(
  parameter int NTHR = NTHR_DEF,
  parameter int TIDW = TIDW_DEF,
  parameter int CCW  = CCW_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                se,
  input  logic [TIDW-1:0]     tid_d,
  input  logic [TIDW-1:0]     tid_e,
  input  logic [TIDW-1:0]     tid_m,
  input  logic [TIDW-1:0]     tid_w,
  input  logic                setcc_d,
  input  logic                rdcc_d,
  input  logic                kill_e,
  input  logic [CCW-1:0]      cc_e,
  input  logic                lw_d,
  input  logic                tlu_update_m,
  input  logic [CCW-1:0]      tlu_ccr_m,
  input  logic                inst_vld_w,
  input  logic                flush_w,
  input  logic                wrccr_w,
  input  logic [CCW-1:0]      wrccr_data_w,
  input  logic                lw_done_g,
  input  logic [TIDW-1:0]     lw_tid_g,
  input  logic [CCW-1:0]      lw_cc_g,
  output logic [CCW-1:0]      cc_d,
  output logic [NTHR*CCW-1:0] ccr_all,
  output logic [NTHR-1:0]     lw_pending,
  output logic                cc_stall_d
);

  // No scan flops are modelled here; se is accepted for interface compatibility
  logic unused_se;
  assign unused_se = se;

  logic            setcc_e, lw_e, setcc_m, lw_m, setcc_w, lw_w, wr2;
  logic [CCW-1:0]  cc_m, cc_w, data_w2;
  logic [TIDW-1:0] tid_w2;

  logic            valid_e, lwv_e, valid_m, ok_w, commit_w;
  logic [CCW-1:0]  ccr_m, data_w;
  logic [CCW-1:0]  ccr_thr [NTHR];

  assign valid_e  = setcc_e & ~kill_e;
  assign lwv_e    = lw_e & ~kill_e;
  assign valid_m  = setcc_m | tlu_update_m;
  assign ccr_m    = tlu_update_m ? tlu_ccr_m : cc_m;
  assign ok_w     = inst_vld_w & ~flush_w;
  assign commit_w = ok_w & (setcc_w | wrccr_w);
  assign data_w   = wrccr_w ? wrccr_data_w : cc_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      setcc_e <= 1'b0;
      lw_e    <= 1'b0;
      setcc_m <= 1'b0;
      lw_m    <= 1'b0;
      setcc_w <= 1'b0;
      lw_w    <= 1'b0;
      wr2     <= 1'b0;
    end else begin
      setcc_e <= setcc_d;
      lw_e    <= lw_d;
      setcc_m <= valid_e;
      lw_m    <= lwv_e;
      setcc_w <= valid_m;
      lw_w    <= lw_m;
      wr2     <= lw_done_g;
    end
  end

  // Datapath flops carry no reset; their valid bits qualify every use
  always_ff @(posedge clk) begin
    cc_m    <= cc_e;
    cc_w    <= ccr_m;
    tid_w2  <= lw_tid_g;
    data_w2 <= lw_cc_g;
  end

  for (genvar t = 0; t < NTHR; t++) begin : g_thr
    logic hit_w, hit_w2;
    assign hit_w  = commit_w & (tid_w == TIDW'(t));
    assign hit_w2 = wr2 & (tid_w2 == TIDW'(t));

    sparc_exu_ccr_thr #(.CCW(CCW)) u_thr (
      .clk      (clk),
      .reset    (reset),
      .wr_w     (hit_w),
      .data_w   (data_w),
      .wr_w2    (hit_w2),
      .data_w2  (data_w2),
      .set_pend (ok_w & lw_w & (tid_w == TIDW'(t))),
      .clr_pend (hit_w2),
      .ccr      (ccr_thr[t]),
      .pending  (lw_pending[t])
    );

    assign ccr_all[t*CCW +: CCW] = ccr_thr[t];
  end

  logic w2_hit_d;
  assign w2_hit_d = wr2 & (tid_w2 == tid_d);

  // Youngest in-flight writer for tid_d wins
  always_comb begin
    cc_d = ccr_thr[tid_d];
    if (valid_e && tid_e == tid_d)
      cc_d = cc_e;
    else if (valid_m && tid_m == tid_d)
      cc_d = ccr_m;
    else if (commit_w && tid_w == tid_d)
      cc_d = data_w;
    else if (w2_hit_d)
      cc_d = data_w2;
  end

  assign cc_stall_d = rdcc_d & lw_pending[tid_d] & ~w2_hit_d;

endmodule
